// File: rtl/input_conditioner.sv
`timescale 1ns/1ps
// input_conditioner
// Conditions two push-buttons and two slide switches coming from the board.
// Each of the four channels runs the same path: polarity normalize, a
// multi-flop synchronizer, a consecutive-cycle debounce counter and a stable
// register. The switch channels expose the stable level directly. The button
// channels expose a single-cycle registered pulse on each accepted press.
// Every output comes straight from a flop, and the asynchronous reset forces
// the whole design to the inactive state.
module input_conditioner #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEB_CYCLES        = 500000,
  parameter int BUTTON_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic async_reset,
  input  logic button0_raw,
  input  logic button1_raw,
  input  logic show_parity_raw,
  input  logic show_history_raw,
  output logic button0_re,
  output logic button1_re,
  output logic show_parity_deb,
  output logic show_history_deb
);

  localparam int NCH = 4;
  localparam int CNT_W = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  // The counter value on which a still-differing input is finally accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic BTN_INV = (BUTTON_ACTIVE_LOW != 0);

  // Returns true on the edge where a differing synchronized level has
  // persisted long enough to replace the stable level.
  function automatic logic deb_accept(input logic s, input logic d,
                                      input logic [CNT_W-1:0] cnt);
    return (s != d) && (cnt == CNT_LAST);
  endfunction

  // After normalization, 1 always means active. The channel order is
  // button0, button1, parity switch, history switch.
  logic [NCH-1:0] norm;
  logic [NCH-1:0] deb;
  logic [1:0]     press;
  logic [1:0]     re_q;

  assign norm = {show_history_raw,
                 show_parity_raw,
                 button1_raw ^ BTN_INV,
                 button0_raw ^ BTN_INV};

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   stable_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchronizer: shift the normalized raw level through SYNC_STAGES flops.
    always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], norm[ch]};
      end
    end

    // Debounce: count consecutive cycles on which s disagrees with the stable
    // level. Any agreement restarts the count.
    always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else if (s == stable_q) begin
        cnt_q <= '0;
      end else if (deb_accept(s, stable_q, cnt_q)) begin
        stable_q <= s;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign deb[ch] = stable_q;

    // Only the button channels generate press pulses. A press is the same
    // acceptance edge on which the stable level rises from 0 to 1.
    if (ch < 2) begin : g_press
      assign press[ch] = deb_accept(s, stable_q, cnt_q) & s;
    end
  end

  // Press pulse registers: set on the edge the stable level rises, and clear
  // on the following edge because the acceptance cannot repeat back to back.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      re_q <= '0;
    end else begin
      re_q <= press;
    end
  end

  assign button0_re       = re_q[0];
  assign button1_re       = re_q[1];
  assign show_parity_deb  = deb[2];
  assign show_history_deb = deb[3];

endmodule

// File: tb/tb_input_conditioner.sv
`timescale 1ns/1ps
// Bench for input_conditioner. It drives a DEB_CYCLES=4 instance and a
// DEB_CYCLES=1 instance from the same inputs. Each scenario is a per-cycle
// table of stimulus and expected outputs. The expected outputs are pushed to a
// scoreboard as stimulus is applied and popped and compared on the falling edge.
module tb_input_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic async_reset;
  logic button0_raw, button1_raw, show_parity_raw, show_history_raw;
  logic b0_re_4, b1_re_4, par_4, hist_4;
  logic b0_re_1, b1_re_1, par_1, hist_1;
  logic [7:0] obs;

  input_conditioner #(.SYNC_STAGES(2), .DEB_CYCLES(4), .BUTTON_ACTIVE_LOW(1)) u_dut (
    .clk(clk), .async_reset(async_reset),
    .button0_raw(button0_raw), .button1_raw(button1_raw),
    .show_parity_raw(show_parity_raw), .show_history_raw(show_history_raw),
    .button0_re(b0_re_4), .button1_re(b1_re_4),
    .show_parity_deb(par_4), .show_history_deb(hist_4)
  );

  input_conditioner #(.SYNC_STAGES(2), .DEB_CYCLES(1), .BUTTON_ACTIVE_LOW(1)) u_dut_d1 (
    .clk(clk), .async_reset(async_reset),
    .button0_raw(button0_raw), .button1_raw(button1_raw),
    .show_parity_raw(show_parity_raw), .show_history_raw(show_history_raw),
    .button0_re(b0_re_1), .button1_re(b1_re_1),
    .show_parity_deb(par_1), .show_history_deb(hist_1)
  );

  // The low nibble holds the DEB_CYCLES=4 outputs and the high nibble holds
  // the DEB_CYCLES=1 outputs.
  assign obs = {hist_1, par_1, b1_re_1, b0_re_1, hist_4, par_4, b1_re_4, b0_re_4};

  // Stimulus bit order is {rst, hist, par, b1, b0}. Idle means buttons
  // released (raw 1) and switches off.
  localparam logic [4:0] IDLE = 5'b00011;

  typedef struct {
    string      tag;
    int         idx;
    logic [7:0] exp;
    logic [7:0] msk;
  } sb_t;

  sb_t        sb_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [4:0] stim_a [128];
  logic [7:0] exp_a  [128];
  int         len;
  logic [7:0] cur_msk;
  string      cur_tag;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  // Scoreboard consumer.
  sb_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check($sformatf("%s[%0d]", mon_e.tag, mon_e.idx), obs & mon_e.msk, mon_e.exp & mon_e.msk);
    end
  end

  task automatic begin_scn(input string tag, input int n, input logic [7:0] msk);
    cur_tag = tag;
    len     = n;
    cur_msk = msk;
    for (int j = 0; j < 128; j++) begin
      stim_a[j] = IDLE;
      exp_a[j]  = 8'h00;
    end
  endtask

  task automatic set_stim(input int from, input int to, input logic [4:0] v);
    for (int j = from; j <= to; j++) stim_a[j] = v;
  endtask

  task automatic or_exp(input int from, input int to, input logic [7:0] v);
    for (int j = from; j <= to; j++) exp_a[j] = exp_a[j] | v;
  endtask

  // For each table row, drive the stimulus just after the rising edge and push
  // that row's expectation. The same cycle's falling edge checks it.
  task automatic play();
    sb_t e;
    for (int j = 0; j < len; j++) begin
      @(posedge clk);
      #1;
      {async_reset, show_history_raw, show_parity_raw, button1_raw, button0_raw} = stim_a[j];
      e.tag = cur_tag;
      e.idx = j;
      e.exp = exp_a[j];
      e.msk = cur_msk;
      sb_q.push_back(e);
    end
    for (int k = 0; k < 4 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    check({cur_tag, "_drain"}, 8'(sb_q.size()), 8'd0);
  endtask

  initial begin
    int   j;
    int   run;
    int   f;
    logic lvl;

    async_reset = 1'b1;
    {show_history_raw, show_parity_raw, button1_raw, button0_raw} = 4'b0011;
    repeat (3) @(posedge clk);

    // Reset pulse with everything idle: all outputs of both builds stay 0.
    begin_scn("reset", 23, 8'hFF);
    set_stim(0, 2, 5'b10011);
    play();

    // Button 0: press, hold, release, press again. Pulses occur at +6 (DEB=4)
    // and at +3 (DEB=1). Releases produce no pulse.
    begin_scn("b0_press", 90, 8'hFF);
    set_stim(0, 49, 5'b00010);
    set_stim(60, 79, 5'b00010);
    or_exp(6, 6, 8'h01);
    or_exp(66, 66, 8'h01);
    or_exp(3, 3, 8'h10);
    or_exp(63, 63, 8'h10);
    play();

    // Button 1 bounce: runs of 1..3 cycles, ending on a released run, then a
    // steady press. The only pulse comes 6 edges after the steady press starts.
    begin_scn("b1_bounce", 0, 8'h0F);
    j   = 0;
    lvl = 1'b0;
    do begin
      run = $urandom_range(1, 3);
      set_stim(j, j + run - 1, lvl ? 5'b00011 : 5'b00001);
      j   = j + run;
      lvl = ~lvl;
    end while (j < 40 || lvl == 1'b1);
    f = j;
    set_stim(f, f + 19, 5'b00001);
    or_exp(f + 6, f + 6, 8'h02);
    len = f + 30;
    play();

    // Switches: parity rises at 0 with a 3-cycle low glitch at 20..22, and
    // falls at 36. History rises at 2 and falls at 40.
    begin_scn("switches", 50, 8'h0F);
    for (int k = 0; k < 50; k++) begin
      stim_a[k][2] = (k < 20) || (k >= 23 && k < 36);
      stim_a[k][3] = (k >= 2 && k < 40);
    end
    or_exp(6, 41, 8'h04);
    or_exp(8, 45, 8'h08);
    play();

    // Both buttons pressed together, released, then pressed again with a
    // reset at cnt=2. The parity switch is held on so the reset visibly clears
    // a live output.
    begin_scn("both_rst", 61, 8'h0F);
    for (int k = 0; k < 61; k++) begin
      stim_a[k][4] = (k == 34 || k == 35);
      stim_a[k][2] = (k < 50);
      stim_a[k][1] = !((k < 15) || (k >= 30 && k < 50));
      stim_a[k][0] = !((k < 15) || (k >= 30 && k < 50));
    end
    or_exp(6, 6, 8'h03);
    or_exp(42, 42, 8'h03);
    or_exp(6, 33, 8'h04);
    or_exp(42, 55, 8'h04);
    play();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
